// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional checksum support is controlled by the BOOT_CHECKSUM_EN macro.
package boot_pkg;

  // Default word-index width (capacity 2**BOOT_ADDR_W words).
  localparam int unsigned BOOT_ADDR_W = 8;

  // Default frame start marker.
  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
`ifdef BOOT_CHECKSUM_EN
    ST_CHK     = 4'd5,
`endif
    ST_DRAIN   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } boot_state_e;

  // Byte acceptance is closed only while draining or parked in a final state.
  function automatic logic st_rx_ready(input boot_state_e s);
    case (s)
      ST_DRAIN, ST_DONE, ST_ERR: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/boot_xor_acc.sv
// 8-bit clear/accumulate XOR register used for the frame checksum.
// Instantiated only when BOOT_CHECKSUM_EN is defined.
module boot_xor_acc
  import boot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_din,
  output logic [7:0] o_acc
);

  logic [7:0] r_acc;

  // Running XOR; clear wins over accumulate so a new frame starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 8'h00;
    end else if (i_clr) begin
      r_acc <= 8'h00;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_din;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader feeding the instruction memory write port of the
// 16-bit MIPS core. Assembles big-endian words from a framed image
// (SYNC, LEN_HI, LEN_LO, LEN x {HI,LO} [, CHK]) and holds the core in reset
// until the image is loaded.
// Macro BOOT_CHECKSUM_EN: adds the trailing CHK byte and XOR verification.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = BOOT_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = BOOT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  // Number of words the memory can hold; LEN above this is rejected.
  localparam logic [16:0] CAP_WORDS = 17'd1 << ADDR_W;

  boot_state_e       r_state;
  boot_state_e       w_next_state;
  logic              r_rx_ready;
  logic              r_imem_we;
  logic [15:0]       r_imem_addr;
  logic [15:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_error;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [7:0]        r_data_hi;
  logic [ADDR_W-1:0] r_index;

  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_len_over;
  logic              w_last_word;

  assign w_xfer      = rx_valid & r_rx_ready;
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_over  = ({1'b0, w_len} > CAP_WORDS);
  assign w_last_word = (16'(r_index) == (r_len - 16'd1));

`ifdef BOOT_CHECKSUM_EN
  logic       w_acc_clr;
  logic       w_acc_en;
  logic [7:0] w_acc;

  // Accumulator restarts when the sync byte is taken (entry to LEN_HI).
  assign w_acc_clr = (r_state == ST_IDLE) && w_xfer && (rx_data == SYNC_BYTE);
  assign w_acc_en  = w_xfer && ((r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                                (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO));

  boot_xor_acc u_xor_acc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_din (rx_data),
    .o_acc (w_acc)
  );

  localparam boot_state_e TAIL_STATE = ST_CHK;
`else
  localparam boot_state_e TAIL_STATE = ST_DRAIN;
`endif

  // Next-state decode; bytes only move the machine on an accepted transfer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && (rx_data == SYNC_BYTE)) w_next_state = ST_LEN_HI;
        else                                  w_next_state = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (w_xfer) w_next_state = ST_LEN_LO;
        else        w_next_state = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (!w_xfer)               w_next_state = ST_LEN_LO;
        else if (w_len_over)       w_next_state = ST_ERR;
        else if (w_len == 16'd0)   w_next_state = TAIL_STATE;
        else                       w_next_state = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        if (w_xfer) w_next_state = ST_DATA_LO;
        else        w_next_state = ST_DATA_HI;
      end
      ST_DATA_LO: begin
        if (!w_xfer)         w_next_state = ST_DATA_LO;
        else if (w_last_word) w_next_state = TAIL_STATE;
        else                 w_next_state = ST_DATA_HI;
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (!w_xfer)              w_next_state = ST_CHK;
        else if (rx_data == w_acc) w_next_state = ST_DRAIN;
        else                      w_next_state = ST_ERR;
      end
`endif
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE, ST_ERR: begin
        if (start) w_next_state = ST_IDLE;
        else       w_next_state = r_state;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, registered status outputs and the memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rx_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 16'h0000;
      r_imem_wdata <= 16'h0000;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_len_hi     <= 8'h00;
      r_len        <= 16'h0000;
      r_data_hi    <= 8'h00;
      r_index      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rx_ready  <= st_rx_ready(w_next_state);
      r_cpu_reset <= (w_next_state != ST_DONE);
      r_done      <= (w_next_state == ST_DONE);
      r_error     <= (w_next_state == ST_ERR);
      r_imem_we   <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI:  r_len_hi <= rx_data;
          ST_LEN_LO: begin
            r_len   <= w_len;
            r_index <= '0;
          end
          ST_DATA_HI: r_data_hi <= rx_data;
          ST_DATA_LO: begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= 16'({r_index, 1'b0});
            r_imem_wdata <= {r_data_hi, rx_data};
            r_index      <= r_index + ADDR_W'(1);
          end
          default: begin
          end
        endcase
      end else if (((r_state == ST_DONE) || (r_state == ST_ERR)) && start) begin
        r_index <= '0;
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (ADDR_W=2 so oversize/full frames are short).
// Follows BOOT_CHECKSUM_EN: frames carry a CHK byte when the macro is defined.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 2;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        start = 1'b0;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];
  logic [15:0] fw[0:7];

  imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Capture every memory write seen between edges.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (rx_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (rx_ready !== 1'b1) begin
      n_total++;
      $display("FAIL rx_ready_wait: rx_ready=%b required 1", rx_ready);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_gb(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    send_byte(b);
  endtask

  // chk_mode: 0 = no CHK byte, 1 = correct CHK, 2 = corrupted CHK (xor 8'h03).
  task automatic send_frame(input logic [15:0] len, input int nwords, input bit gaps, input int chk_mode);
    logic [7:0] x;
    x = len[15:8] ^ len[7:0];
    send_gb(8'hA5, gaps);
    send_gb(len[15:8], gaps);
    send_gb(len[7:0], gaps);
    for (int i = 0; i < nwords; i++) begin
      send_gb(fw[i][15:8], gaps);
      send_gb(fw[i][7:0], gaps);
      x = x ^ fw[i][15:8] ^ fw[i][7:0];
    end
    if (chk_mode == 1) send_gb(x, gaps);
    else if (chk_mode == 2) send_gb(x ^ 8'h03, gaps);
  endtask

  task automatic wait_end(input string tag);
    int g = 0;
    while (done !== 1'b1 && error !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL %s_done: done=%b required 1", tag, done); else n_pass++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL restart_idle: cpu_reset=%b done=%b error=%b rx_ready=%b required 1/0/0/1",
               cpu_reset, done, error, rx_ready);
    else n_pass++;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    n_total++; if (rx_ready !== 1'b1) $display("FAIL %s_rx_ready: got %b required 1", tag, rx_ready); else n_pass++;
    n_total++; if (imem_we !== 1'b0) $display("FAIL %s_imem_we: got %b required 0", tag, imem_we); else n_pass++;
    n_total++; if (imem_addr !== 16'h0000) $display("FAIL %s_imem_addr: got %h required 0000", tag, imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 16'h0000) $display("FAIL %s_imem_wdata: got %h required 0000", tag, imem_wdata); else n_pass++;
    n_total++; if (cpu_reset !== 1'b1) $display("FAIL %s_cpu_reset: got %b required 1", tag, cpu_reset); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL %s_done: got %b required 0", tag, done); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL %s_error: got %b required 0", tag, error); else n_pass++;
  endtask

  task automatic test_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_two_word();
    q_addr.delete();
    q_data.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    n_total++; if (imem_we !== 1'b1) $display("FAIL two_last_we: got %b required 1", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 16'h0002) $display("FAIL two_last_addr: got %h required 0002", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 16'hABCD) $display("FAIL two_last_data: got %h required abcd", imem_wdata); else n_pass++;
    if (CHK_ON) send_byte(8'h42);
    n_total++; if (done !== 1'b0 || cpu_reset !== 1'b1 || rx_ready !== 1'b0)
      $display("FAIL two_drain: done=%b cpu_reset=%b rx_ready=%b required 0/1/0", done, cpu_reset, rx_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b1 || cpu_reset !== 1'b0)
      $display("FAIL two_done_timing: done=%b cpu_reset=%b required 1/0", done, cpu_reset); else n_pass++;
    n_total++; if (q_addr.size() != 2) $display("FAIL two_wr_count: got %0d required 2", q_addr.size()); else n_pass++;
    n_total++; if (q_addr[0] !== 16'h0000 || q_data[0] !== 16'h1234)
      $display("FAIL two_wr0: addr=%h data=%h required 0000/1234", q_addr[0], q_data[0]); else n_pass++;
    n_total++; if (q_addr[1] !== 16'h0002 || q_data[1] !== 16'hABCD)
      $display("FAIL two_wr1: addr=%h data=%h required 0002/abcd", q_addr[1], q_data[1]); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (done !== 1'b1 || rx_ready !== 1'b0)
      $display("FAIL two_hold: done=%b rx_ready=%b required 1/0", done, rx_ready); else n_pass++;
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    fw[0] = 16'h1234;
    send_frame(16'h0001, 1, 1'b0, 2);
    repeat (2) @(negedge clk);
    n_total++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0)
      $display("FAIL chk_bad: error=%b cpu_reset=%b done=%b required 1/1/0", error, cpu_reset, done); else n_pass++;
    pulse_start();
    send_frame(16'h0001, 1, 1'b0, 1);
    wait_end("chk_good");
    n_total++; if (error !== 1'b0 || cpu_reset !== 1'b0)
      $display("FAIL chk_good_flags: error=%b cpu_reset=%b required 0/0", error, cpu_reset); else n_pass++;
  endtask
`endif

  task automatic test_oversize();
    pulse_start();
    send_frame(16'h0005, 0, 1'b0, 0);
    n_total++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL over_err: error=%b done=%b cpu_reset=%b required 1/0/1", error, done, cpu_reset); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (q_addr.size() != 0) $display("FAIL over_no_write: got %0d writes required 0", q_addr.size()); else n_pass++;
    n_total++; if (error !== 1'b1) $display("FAIL over_sticky: error=%b required 1", error); else n_pass++;
  endtask

  task automatic test_full_capacity();
    pulse_start();
    fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333; fw[3] = 16'h4444;
    send_frame(16'h0004, 4, 1'b0, CHK_ON ? 1 : 0);
    wait_end("full");
    n_total++; if (q_addr.size() != 4) $display("FAIL full_count: got %0d required 4", q_addr.size()); else n_pass++;
    n_total++; if (q_addr[3] !== 16'h0006 || q_data[3] !== 16'h4444)
      $display("FAIL full_last: addr=%h data=%h required 0006/4444", q_addr[3], q_data[3]); else n_pass++;
  endtask

  task automatic test_empty();
    pulse_start();
    send_frame(16'h0000, 0, 1'b0, CHK_ON ? 1 : 0);
    wait_end("empty");
    n_total++; if (q_addr.size() != 0) $display("FAIL empty_writes: got %0d required 0", q_addr.size()); else n_pass++;
  endtask

  task automatic test_noise_stalls();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'hFF);
    n_total++; if (rx_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL noise_idle: rx_ready=%b done=%b required 1/0", rx_ready, done); else n_pass++;
    fw[0] = 16'h0001; fw[1] = 16'hBEEF;
    send_frame(16'h0002, 2, 1'b1, CHK_ON ? 1 : 0);
    wait_end("stall");
    n_total++; if (q_addr.size() != 2) $display("FAIL stall_count: got %0d required 2", q_addr.size()); else n_pass++;
    n_total++; if (q_addr[0] !== 16'h0000 || q_data[0] !== 16'h0001)
      $display("FAIL stall_wr0: addr=%h data=%h required 0000/0001", q_addr[0], q_data[0]); else n_pass++;
    n_total++; if (q_addr[1] !== 16'h0002 || q_data[1] !== 16'hBEEF)
      $display("FAIL stall_wr1: addr=%h data=%h required 0002/beef", q_addr[1], q_data[1]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h77); send_byte(8'h66); send_byte(8'h12);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q_addr.delete();
    q_data.delete();
    fw[0] = 16'h5678;
    send_frame(16'h0001, 1, 1'b0, CHK_ON ? 1 : 0);
    wait_end("fresh");
    n_total++; if (q_addr.size() != 1 || q_addr[0] !== 16'h0000 || q_data[0] !== 16'h5678)
      $display("FAIL fresh_wr: count=%0d addr=%h data=%h required 1/0000/5678", q_addr.size(), q_addr[0], q_data[0]);
    else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_word();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    test_oversize();
    test_full_capacity();
    test_empty();
    test_noise_stalls();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
